reset_sequencer: RTL and testbench

- Z80 SoC reset controller: merges power-on reset (reset_n), the watchdog's `reset` request, an external push-button and a software reset into one stretched system reset, sys_reset_n.
- sys_reset_n drives the CPU and all peripherals, including the watchdog's own reset_n, so the watchdog request clears through this block.
- Exposes a reset-cause register and a reset counter on the Z80 I/O bus, so firmware can tell why it restarted.

---
 rtl/reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Z80 SoC reset controller: merges power-on, watchdog, push-button and software
// reset requests into one stretched, registered system reset with cause/count registers.
module reset_sequencer #(
    parameter int          STRETCH_CYCLES  = 16,
    parameter int          DEBOUNCE_CYCLES = 1024,
    parameter logic [7:0]  SOFT_KEY        = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wdt_req,
    input  logic       btn_n,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    output logic       sys_reset_n
);

    localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] STRETCH_LAST  = SW'(STRETCH_CYCLES - 1);
    localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_STRETCH = 2'd2;

    logic          btn_s1_q, btn_s1_d;
    logic          btn_s2_q, btn_s2_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [SW-1:0] str_cnt_q, str_cnt_d;
    logic          sys_reset_n_q, sys_reset_n_d;
    logic [3:0]    cause_q, cause_d;
    logic [7:0]    rst_count_q, rst_count_d;

    logic write_sel, read_sel;
    logic btn_req, req, soft_key_wr;
    logic [3:0] cause_set, cause_clr;

    assign write_sel   = !cs_n && rd_n && !wr_n;
    assign read_sel    = !cs_n && !rd_n && wr_n;
    assign btn_req     = (deb_cnt_q == DEBOUNCE_LAST);
    assign req         = wdt_req || btn_req;
    assign soft_key_wr = write_sel && (addr == 2'b01) && (data_in == SOFT_KEY)
                         && (state_q == ST_RUN);
    assign sys_reset_n = sys_reset_n_q;

    // Debounce counter saturates at its last value so btn_req stays high while held.
    always_comb begin
        btn_s1_d  = btn_n;
        btn_s2_d  = btn_s1_q;
        deb_cnt_d = deb_cnt_q;
        if (btn_s2_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEBOUNCE_LAST) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        str_cnt_d = str_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (req) begin
                    state_d   = ST_HOLD;
                    str_cnt_d = '0;
                end else if (soft_key_wr) begin
                    state_d   = ST_STRETCH;
                    str_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (!req) begin
                    state_d   = ST_STRETCH;
                    str_cnt_d = '0;
                end
            end
            ST_STRETCH: begin
                if (req) begin
                    state_d   = ST_HOLD;
                    str_cnt_d = '0;
                end else if (str_cnt_q == STRETCH_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    str_cnt_d = str_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_STRETCH;
                str_cnt_d = '0;
            end
        endcase
        sys_reset_n_d = (state_d == ST_RUN);
    end

    // Cause bits are sticky; a set in the same cycle beats a write-1-to-clear.
    always_comb begin
        cause_set   = {soft_key_wr, wdt_req, btn_req, 1'b0};
        cause_clr   = (write_sel && (addr == 2'b00)) ? data_in[3:0] : 4'h0;
        cause_d     = (cause_q & ~cause_clr) | cause_set;
        rst_count_d = rst_count_q;
        if ((state_q == ST_RUN) && (state_d != ST_RUN) && (rst_count_q != 8'hFF)) begin
            rst_count_d = rst_count_q + 8'd1;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (read_sel) begin
            case (addr)
                2'b00:   data_out = {4'h0, cause_q};
                2'b01:   data_out = rst_count_q;
                2'b10:   data_out = {6'b0, wdt_req, !btn_s2_q};
                default: data_out = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_s1_q      <= 1'b1;
            btn_s2_q      <= 1'b1;
            deb_cnt_q     <= '0;
            state_q       <= ST_STRETCH;
            str_cnt_q     <= '0;
            sys_reset_n_q <= 1'b0;
            cause_q       <= 4'h1;
            rst_count_q   <= 8'h00;
        end else begin
            btn_s1_q      <= btn_s1_d;
            btn_s2_q      <= btn_s2_d;
            deb_cnt_q     <= deb_cnt_d;
            state_q       <= state_d;
            str_cnt_q     <= str_cnt_d;
            sys_reset_n_q <= sys_reset_n_d;
            cause_q       <= cause_d;
            rst_count_q   <= rst_count_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expectations are queued as stimulus is
// applied and popped when the corresponding DUT value is observed.
module tb_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       wdt_req;
    logic       btn_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] addr;
    logic       sys_reset_n;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } expect_t;

    expect_t scoreboard[$];
    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .STRETCH_CYCLES (16),
        .DEBOUNCE_CYCLES(1024),
        .SOFT_KEY       (8'hA5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wdt_req    (wdt_req),
        .btn_n      (btn_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .addr       (addr),
        .sys_reset_n(sys_reset_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic pushExpect(input string tag, input logic [31:0] exp);
        expect_t e;
        e.tag = tag;
        e.exp = exp;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        expect_t e;
        checks++;
        if (scoreboard.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=%0h expected=<entry>", observed);
        end else begin
            e = scoreboard.pop_front();
            assert (observed === e.exp)
            else begin
                errors++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.exp);
            end
        end
    endtask

    // Bus write: called on a negedge, held across one posedge.
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        addr    = a;
        data_in = d;
        @(negedge clk);
        cs_n    = 1'b1;
        wr_n    = 1'b1;
        data_in = 8'h00;
    endtask

    task automatic busRead(input logic [1:0] a, input string tag, input logic [7:0] exp);
        cs_n = 1'b0;
        rd_n = 1'b0;
        addr = a;
        pushExpect(tag, {24'h0, exp});
        #1;
        checkOutput({24'h0, data_out});
        cs_n = 1'b1;
        rd_n = 1'b1;
    endtask

    // Counts consecutive sampled-low negedges starting with the current one.
    task automatic measureLow(input int limit, output int n);
        n = 0;
        while (sys_reset_n === 1'b0 && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int firstLow;
        logic lowSeen;

        reset_n = 1'b0;
        wdt_req = 1'b0;
        btn_n   = 1'b1;
        data_in = 8'h00;
        cs_n    = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        addr    = 2'b00;

        // Power-on reset and release
        repeat (5) @(negedge clk);
        pushExpect("por_sys_low", 32'd0);
        checkOutput({31'h0, sys_reset_n});
        reset_n = 1'b1;
        pushExpect("por_stretch_len", 32'd16);
        measureLow(100, n);
        checkOutput(n);
        busRead(2'b00, "por_cause", 8'h01);
        busRead(2'b01, "por_count", 8'h00);

        // Watchdog request held for 3 cycles
        wdt_req = 1'b1;
        #1;
        pushExpect("wdt_latency_still_high", 32'd1);
        checkOutput({31'h0, sys_reset_n});
        @(negedge clk);
        pushExpect("wdt_fall", 32'd0);
        checkOutput({31'h0, sys_reset_n});
        @(negedge clk);
        @(negedge clk);
        wdt_req = 1'b0;
        pushExpect("wdt_low_len", 32'd19);
        measureLow(100, n);
        checkOutput(n + 2);
        busRead(2'b00, "wdt_cause", 8'h05);
        busRead(2'b01, "wdt_count", 8'h01);

        // W1C then software reset
        applyStimulus(2'b00, 8'h01);
        busRead(2'b00, "w1c_por", 8'h04);
        applyStimulus(2'b00, 8'h04);
        busRead(2'b00, "w1c_wdt", 8'h00);
        applyStimulus(2'b01, 8'hA5);
        pushExpect("soft_low_len", 32'd16);
        measureLow(100, n);
        checkOutput(n);
        busRead(2'b00, "soft_cause", 8'h08);
        busRead(2'b01, "soft_count", 8'h02);

        // Wrong key does nothing
        applyStimulus(2'b01, 8'h5A);
        lowSeen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (sys_reset_n !== 1'b1) lowSeen = 1'b1;
            @(negedge clk);
        end
        pushExpect("badkey_no_reset", 32'd0);
        checkOutput({31'h0, lowSeen});
        busRead(2'b01, "badkey_count", 8'h02);
        busRead(2'b00, "badkey_cause", 8'h08);

        // Button glitch shorter than debounce window
        btn_n   = 1'b0;
        lowSeen = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (sys_reset_n !== 1'b1) lowSeen = 1'b1;
            if (i == 10) busRead(2'b10, "status_pressed", 8'h01);
        end
        btn_n = 1'b1;
        repeat (5) @(negedge clk);
        pushExpect("glitch_no_reset", 32'd0);
        checkOutput({31'h0, lowSeen});
        busRead(2'b10, "status_released", 8'h00);

        // Long button press
        btn_n    = 1'b0;
        firstLow = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (firstLow == 0 && sys_reset_n === 1'b0) firstLow = i;
        end
        pushExpect("btn_first_low", 32'd1026);
        checkOutput(firstLow);
        btn_n = 1'b1;
        pushExpect("btn_release_low_len", 32'd20);
        measureLow(100, n);
        checkOutput(n);
        busRead(2'b00, "btn_cause", 8'h0A);
        busRead(2'b01, "btn_count", 8'h03);

        // Watchdog re-asserted mid-stretch restarts the stretch
        applyStimulus(2'b01, 8'hA5);
        repeat (10) @(negedge clk);
        pushExpect("restretch_low_at_10", 32'd0);
        checkOutput({31'h0, sys_reset_n});
        wdt_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wdt_req = 1'b0;
        pushExpect("restretch_low_len", 32'd17);
        measureLow(100, n);
        checkOutput(n);
        busRead(2'b01, "restretch_count", 8'h04);
        busRead(2'b00, "restretch_cause", 8'h0E);

        // Set beats clear in the same cycle
        wdt_req = 1'b1;
        applyStimulus(2'b00, 8'h04);
        wdt_req = 1'b0;
        pushExpect("setclr_reset_seen", 32'd1);
        measureLow(100, n);
        checkOutput({31'h0, (n > 0)});
        busRead(2'b00, "setclr_cause", 8'h0E);
        busRead(2'b01, "setclr_count", 8'h05);

        // Counter saturation
        for (int i = 0; i < 256; i++) begin
            applyStimulus(2'b01, 8'hA5);
            measureLow(100, n);
        end
        busRead(2'b01, "count_saturated", 8'hFF);

        // reset_n mid-operation
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        pushExpect("midreset_sys_low", 32'd0);
        checkOutput({31'h0, sys_reset_n});
        busRead(2'b00, "midreset_cause", 8'h01);
        busRead(2'b01, "midreset_count", 8'h00);
        reset_n = 1'b1;
        pushExpect("midreset_stretch_len", 32'd16);
        measureLow(100, n);
        checkOutput(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
